// File: rtl/rx_matched_decim.sv
// Receive matched filter with decimation: one 5-tap MAC output per DECIM accepted samples.
// Build option: define RX_ROUND_EN for round-half-up products; otherwise products truncate.
module rx_matched_decim #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned PW    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [11:0]   rx_in,
    input  logic          in_valid,
    input  logic [PW-1:0] phase_sel,
    input  logic [11:0]   c0,
    input  logic [11:0]   c1,
    input  logic [11:0]   c2,
    input  logic [11:0]   c3,
    input  logic [11:0]   c4,
    output logic [21:0]   rx_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    localparam int unsigned XW  = 12;
    localparam int unsigned CW  = 12;
    localparam int unsigned MW  = 24;
    localparam int unsigned PRW = 20;
    localparam int unsigned AW  = 22;
    localparam int unsigned NT  = 5;
    localparam int unsigned KW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [XW-1:0]  x    [NT];
    logic signed [XW-1:0]  snap [NT];
    logic signed [AW-1:0]  acc;
    logic [KW-1:0]         k;
    logic [PW-1:0]         phase;

    logic                  trigger_c;
    logic                  start_c;
    logic                  acc_en_c;
    logic                  load_out_c;
    logic                  drop_c;

    logic signed [XW-1:0]  a_sel;
    logic signed [CW-1:0]  c_sel;
    logic signed [MW-1:0]  a_ext;
    logic signed [MW-1:0]  c_ext;
    logic signed [MW-1:0]  tmp;
    logic signed [PRW-1:0] prod_r;
    logic signed [PRW-1:0] prod;
    logic signed [AW-1:0]  prod_ext;
    logic                  sat_c;

    // Phase compare uses the counter value before this sample's increment.
    assign trigger_c = in_valid && (phase == phase_sel);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        state_nxt  = state;
        start_c    = 1'b0;
        acc_en_c   = 1'b0;
        load_out_c = 1'b0;
        drop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger_c) begin
                    start_c   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                acc_en_c = 1'b1;
                drop_c   = trigger_c;
                if (k == KW'(NT - 1)) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                load_out_c = 1'b1;
                drop_c     = trigger_c;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tap select for the shared multiplier
    always_comb begin
        a_sel = '0;
        c_sel = '0;
        case (k)
            3'd0: begin a_sel = snap[0]; c_sel = $signed(c0); end
            3'd1: begin a_sel = snap[1]; c_sel = $signed(c1); end
            3'd2: begin a_sel = snap[2]; c_sel = $signed(c2); end
            3'd3: begin a_sel = snap[3]; c_sel = $signed(c3); end
            3'd4: begin a_sel = snap[4]; c_sel = $signed(c4); end
            default: begin
                a_sel = '0;
                c_sel = '0;
            end
        endcase
    end

    // Q.21 product reduced to 20.18; only -2048 * -2048 can exceed the range
    always_comb begin
        a_ext = {{(MW - XW){a_sel[XW-1]}}, a_sel};
        c_ext = {{(MW - CW){c_sel[CW-1]}}, c_sel};
        tmp   = a_ext * c_ext;
        sat_c = (tmp == $signed(MW'(24'h400000)));
`ifdef RX_ROUND_EN
        prod_r = tmp[22:3] + $signed({{(PRW - 1){1'b0}}, tmp[2]});
`else
        prod_r = tmp[22:3];
`endif
        prod     = sat_c ? $signed(PRW'(20'h7FFFF)) : prod_r;
        prod_ext = {{(AW - PRW){prod[PRW-1]}}, prod};
    end

    // Delay line, phase counter and snapshot
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NT; i++) begin
                x[i]    <= '0;
                snap[i] <= '0;
            end
            phase <= '0;
        end else begin
            if (in_valid) begin
                x[0] <= $signed(rx_in);
                for (int i = 1; i < NT; i++) begin
                    x[i] <= x[i-1];
                end
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
            end
            if (start_c) begin
                snap[0] <= $signed(rx_in);
                for (int i = 1; i < NT; i++) begin
                    snap[i] <= x[i-1];
                end
            end
        end
    end

    // Accumulator and tap index
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
            k   <= '0;
        end else if (start_c) begin
            acc <= '0;
            k   <= '0;
        end else if (acc_en_c) begin
            acc <= acc + prod_ext;
            k   <= k + KW'(1);
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_out    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= load_out_c;
            if (load_out_c) begin
                rx_out <= acc;
            end
            busy    <= (state_nxt != IDLE);
            overrun <= overrun | drop_c;
        end
    end

endmodule

// File: tb/tb_rx_matched_decim.sv
// Directed self-checking bench for rx_matched_decim (expectations follow RX_ROUND_EN).
module tb_rx_matched_decim;

    logic        clk;
    logic        rstn;
    logic [11:0] rx_in;
    logic        in_valid;
    logic [1:0]  phase_sel;
    logic [11:0] c0, c1, c2, c3, c4;
    logic [21:0] rx_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_chk;
    int n_pass;

    rx_matched_decim #(.DECIM(4), .PW(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_in     (rx_in),
        .in_valid  (in_valid),
        .phase_sel (phase_sel),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .rx_out    (rx_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rstn     = 1'b0;
        in_valid = 1'b0;
        rx_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_coefs(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                             input logic [11:0] a3, input logic [11:0] a4);
        c0 = a0; c1 = a1; c2 = a2; c3 = a3; c4 = a4;
    endtask

    // One valid sample, then idle; counts out_valid pulses over the following cycles.
    task automatic send(input logic [11:0] s, input int cycles, output int n_out, output logic [21:0] val);
        n_out    = 0;
        val      = '0;
        rx_in    = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rx_in    = '0;
        for (int j = 1; j < cycles; j++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n_out++;
                val = rx_out;
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        do_reset();
        n_chk++; if (rx_out !== 22'd0) $display("FAIL reset_rx_out: got %0d want 0", rx_out); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) pulses++;
        end
        n_chk++; if (pulses != 0) $display("FAIL idle_no_output: got %0d pulses want 0", pulses); else n_pass++;
    endtask

    task automatic test_single_tap();
        int busy_cnt;
        int early;
        do_reset();
        set_coefs(12'd1024, 12'd0, 12'd0, 12'd0, 12'd0);
        phase_sel = 2'd0;
        rx_in     = 12'd512;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rx_in    = '0;
        busy_cnt = 0;
        early    = 0;
        for (int j = 0; j < 6; j++) begin
            if (busy === 1'b1) busy_cnt++;
            if (out_valid !== 1'b0) early++;
            @(posedge clk);
            #1;
        end
        n_chk++; if (busy_cnt != 6) $display("FAIL single_busy_cycles: got %0d want 6", busy_cnt); else n_pass++;
        n_chk++; if (early != 0) $display("FAIL single_early_valid: got %0d want 0", early); else n_pass++;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL single_valid_e6: got %b want 1", out_valid); else n_pass++;
        n_chk++; if (rx_out !== 22'd65536) $display("FAIL single_rx_out: got %0d want 65536", rx_out); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else n_pass++;
        @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL single_valid_e7: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_impulse();
        int          n_out;
        logic [21:0] val;
        int          total;
        logic [21:0] got [3];
        logic [21:0] exp_v [3];
        do_reset();
        set_coefs(12'd1024, 12'd512, 12'd256, 12'd128, 12'd64);
        phase_sel = 2'd0;
        exp_v[0] = 22'd65536;
        exp_v[1] = 22'd4096;
        exp_v[2] = 22'd0;
        total = 0;
        for (int i = 0; i < 9; i++) begin
            send((i == 0) ? 12'd512 : 12'd0, 8, n_out, val);
            if (n_out > 0) begin
                if (total < 3) got[total] = val;
                total = total + n_out;
            end
        end
        n_chk++; if (total != 3) $display("FAIL impulse_count: got %0d want 3", total); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (total <= i) $display("FAIL impulse_out%0d: missing output want %0d", i, exp_v[i]);
            else if (got[i] !== exp_v[i]) $display("FAIL impulse_out%0d: got %0d want %0d", i, got[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rounding();
        int          n_out;
        logic [21:0] val;
        logic [21:0] exp_pos;
`ifdef RX_ROUND_EN
        exp_pos = 22'd1;
`else
        exp_pos = 22'd0;
`endif
        do_reset();
        set_coefs(12'd5, 12'd0, 12'd0, 12'd0, 12'd0);
        phase_sel = 2'd0;
        send(12'd1, 8, n_out, val);
        n_chk++; if (n_out != 1 || val !== exp_pos) $display("FAIL round_pos: got %0d (n=%0d) want %0d", val, n_out, exp_pos); else n_pass++;
        do_reset();
        send(12'hFFF, 8, n_out, val);
        n_chk++; if (n_out != 1 || val !== 22'h3FFFFF) $display("FAIL round_neg: got %h (n=%0d) want 3fffff", val, n_out); else n_pass++;
    endtask

    task automatic test_saturation();
        int          n_out;
        logic [21:0] val;
        do_reset();
        set_coefs(12'h800, 12'd0, 12'd0, 12'd0, 12'd0);
        phase_sel = 2'd0;
        send(12'h800, 8, n_out, val);
        n_chk++; if (n_out != 1 || val !== 22'd524287) $display("FAIL saturation: got %0d (n=%0d) want 524287", val, n_out); else n_pass++;
    endtask

    task automatic test_phase_sel();
        int          n_out;
        logic [21:0] val;
        int          early;
        do_reset();
        set_coefs(12'd1024, 12'd0, 12'd0, 12'd0, 12'd0);
        phase_sel = 2'd2;
        early = 0;
        send(12'd100, 8, n_out, val);
        early = early + n_out;
        send(12'd200, 8, n_out, val);
        early = early + n_out;
        n_chk++; if (early != 0) $display("FAIL phase_early: got %0d pulses want 0", early); else n_pass++;
        send(12'd300, 8, n_out, val);
        n_chk++; if (n_out != 1 || val !== 22'd38400) $display("FAIL phase_out: got %0d (n=%0d) want 38400", val, n_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          pulses;
        logic [21:0] val;
        do_reset();
        set_coefs(12'd1024, 12'd0, 12'd0, 12'd0, 12'd0);
        phase_sel = 2'd0;
        pulses = 0;
        val    = '0;
        for (int i = 0; i < 8; i++) begin
            rx_in    = (i == 0) ? 12'd512 : 12'd0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                val = rx_out;
            end
            if (i == 3) begin
                n_chk++; if (overrun !== 1'b0) $display("FAIL overrun_before: got %b want 0", overrun); else n_pass++;
            end
            if (i == 4) begin
                n_chk++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else n_pass++;
            end
        end
        in_valid = 1'b0;
        rx_in    = '0;
        n_chk++; if (pulses != 1) $display("FAIL overrun_pulses: got %0d want 1", pulses); else n_pass++;
        n_chk++; if (val !== 22'd65536) $display("FAIL overrun_value: got %0d want 65536", val); else n_pass++;
        n_chk++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else n_pass++;
    endtask

    task automatic test_midop_reset();
        int pulses;
        do_reset();
        set_coefs(12'd1024, 12'd0, 12'd0, 12'd0, 12'd0);
        phase_sel = 2'd0;
        rx_in     = 12'd512;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rx_in    = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b1) $display("FAIL midop_busy: got %b want 1", busy); else n_pass++;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) pulses++;
        end
        n_chk++; if (pulses != 0) $display("FAIL midop_no_output: got %0d pulses want 0", pulses); else n_pass++;
        n_chk++; if (rx_out !== 22'd0) $display("FAIL midop_rx_out: got %0d want 0", rx_out); else n_pass++;
        n_chk++; if (busy !== 1'b0 || overrun !== 1'b0) $display("FAIL midop_flags: got busy=%b overrun=%b want 0 0", busy, overrun); else n_pass++;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rstn      = 1'b0;
        rx_in     = '0;
        in_valid  = 1'b0;
        phase_sel = '0;
        set_coefs(12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
        test_reset();
        test_single_tap();
        test_impulse();
        test_rounding();
        test_saturation();
        test_phase_sel();
        test_back_to_back();
        test_midop_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
